fetch_queue: RTL and testbench

//  Parametrised LANES-wide fetch front end: owns the fetch PC, issues block reads to a sync

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Summary  : LANES-wide fetch front end: owns the fetch PC, issues block reads
//            to a 1-cycle imem and buffers returned instructions with PCs.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int          LANES    = 2,
  parameter int          DEPTH    = 8,
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                         clock_i,
  input  logic                         reset_n_i,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic                         imem_req_o,
  output logic [ADDR_W-1:0]            imem_addr_o,
  input  logic [32*LANES-1:0]          imem_data_i,
  input  logic [$clog2(LANES+1)-1:0]   deq_count_i,
  output logic [LANES-1:0]             valid_o,
  output logic [32*LANES-1:0]          inst_o,
  output logic [32*LANES-1:0]          pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int          c_b        = $clog2(LANES);
  localparam int          c_pw       = $clog2(DEPTH);
  localparam int          c_cw       = $clog2(DEPTH+1);
  localparam logic [31:0] c_blk_mask = ~(32'(4*LANES) - 32'd1);

  logic [31:0]     r_fpc;
  logic [31:0]     r_rsp_pc;
  logic            r_inflight;
  logic [c_pw-1:0] r_head;
  logic [c_pw-1:0] r_tail;
  logic [c_cw-1:0] r_count;
  logic [31:0]     r_inst_mem [DEPTH];
  logic [31:0]     r_pc_mem   [DEPTH];

  logic            w_space_ok;
  logic [31:0]     w_fpc_next;
  logic [c_b+1:0]  w_rsp_lo;
  logic [c_b+1:0]  w_off;
  logic [31:0]     w_rsp_base;
  logic [c_cw-1:0] w_enq_n;
  logic [c_cw-1:0] w_deq_lim;
  logic [c_cw-1:0] w_deq_n;
  logic            w_wr_en;
  logic [c_pw-1:0] w_slot [LANES];

  // Credit counts the in-flight block so a returning response always fits.
  assign w_space_ok  = (32'(r_count) + (r_inflight ? 32'(LANES) : 32'd0) + 32'(LANES))
                       <= 32'(DEPTH);
  assign imem_req_o  = reset_n_i & ~redirect_i & w_space_ok;
  assign imem_addr_o = r_fpc[ADDR_W+c_b+1 : c_b+2];
  assign w_fpc_next  = (r_fpc & c_blk_mask) + 32'(4*LANES);

  // An unaligned start PC skips the leading lanes of its block.
  assign w_rsp_lo    = r_rsp_pc[c_b+1:0];
  assign w_off       = w_rsp_lo >> 2;
  assign w_rsp_base  = r_rsp_pc & c_blk_mask;
  assign w_enq_n     = r_inflight ? (c_cw'(LANES) - c_cw'(w_off)) : '0;
  assign w_wr_en     = reset_n_i & ~redirect_i & r_inflight;

  assign w_deq_lim   = (32'(deq_count_i) > 32'(LANES)) ? c_cw'(LANES) : c_cw'(deq_count_i);
  assign w_deq_n     = (w_deq_lim > r_count) ? r_count : w_deq_lim;
  assign count_o     = r_count;

  for (genvar j = 0; j < LANES; j++) begin : g_slot
    assign w_slot[j] = r_tail + c_pw'(j) - c_pw'(w_off);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_out
    logic [c_pw-1:0] w_idx;
    assign w_idx               = r_head + c_pw'(i);
    assign valid_o[i]          = r_count > c_cw'(i);
    assign inst_o[32*i +: 32]  = valid_o[i] ? r_inst_mem[w_idx] : 32'd0;
    assign pc_o[32*i +: 32]    = valid_o[i] ? r_pc_mem[w_idx]   : 32'd0;
  end

  always_ff @(posedge clock_i) begin
    if (w_wr_en) begin
      for (int j = 0; j < LANES; j++) begin
        if (j >= int'(w_off)) begin
          r_inst_mem[w_slot[j]] <= imem_data_i[32*j +: 32];
          r_pc_mem[w_slot[j]]   <= w_rsp_base + 32'(4*j);
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      r_fpc      <= RESET_PC;
      r_rsp_pc   <= '0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else if (redirect_i) begin
      // Dropping inflight discards a response arriving this very cycle.
      r_fpc      <= redirect_pc_i & ~32'd3;
      r_inflight <= 1'b0;
      r_head     <= r_tail;
      r_count    <= '0;
    end else begin
      r_inflight <= imem_req_o;
      if (imem_req_o) begin
        r_rsp_pc <= r_fpc;
        r_fpc    <= w_fpc_next;
      end
      r_head  <= r_head + c_pw'(w_deq_n);
      r_tail  <= r_tail + c_pw'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Summary  : Directed bench for fetch_queue with an expected-PC scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

  localparam int LANES  = 2;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 10;

  logic              clock_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic              redirect_i = 1'b0;
  logic [31:0]       redirect_pc_i = 32'h0;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [63:0]       imem_data_i = '0;
  logic [1:0]        deq_count_i = 2'd0;
  logic [1:0]        valid_o;
  logic [63:0]       inst_o;
  logic [63:0]       pc_o;
  logic [3:0]        count_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];

  fetch_queue #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i), .deq_count_i(deq_count_i), .valid_o(valid_o),
    .inst_o(inst_o), .pc_o(pc_o), .count_o(count_o)
  );

  always #5 clock_i = ~clock_i;

  // Synchronous imem: each word holds its own byte address.
  always @(posedge clock_i) begin
    if (imem_req_o)
      imem_data_i <= {({22'b0, imem_addr_o} << 3) + 32'd4, {22'b0, imem_addr_o} << 3};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every lane decode consumes must match the next expected PC.
  always @(negedge clock_i) begin
    logic [31:0] e;
    if (reset_n_i === 1'b1 && redirect_i === 1'b0) begin
      for (int i = 0; i < LANES; i++) begin
        if (i < int'(deq_count_i) && valid_o[i] === 1'b1) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mon_extra: lane %0d pc 0x%0h with no expected entry", i, pc_o[32*i +: 32]);
          end else begin
            e = exp_q.pop_front();
            chk("mon_pc", 64'(pc_o[32*i +: 32]), 64'(e));
            chk("mon_inst", 64'(inst_o[32*i +: 32]), 64'(e));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic settle();
    @(negedge clock_i);
  endtask

  task automatic do_reset();
    reset_n_i  = 1'b0;
    redirect_i = 1'b0;
    deq_count_i = 2'd0;
    exp_q.delete();
    settle();
    chk("rst_req", 64'(imem_req_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    // Fill with no dequeue: four block requests, then stall while full.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      settle();
      if (c == 0) begin
        chk("t1_cnt0", 64'(count_o), 64'd0);
        chk("t1_val0", 64'(valid_o), 64'd0);
        chk("t1_pc0", pc_o, 64'd0);
        chk("t1_inst0", inst_o, 64'd0);
      end
      chk("t1_req", 64'(imem_req_o), 64'(c < 4));
      if (c < 4) chk("t1_addr", 64'(imem_addr_o), 64'(c));
      tick();
    end
    settle();
    chk("t1_full_cnt", 64'(count_o), 64'd8);
    chk("t1_full_val", 64'(valid_o), 64'd3);
    chk("t1_full_pc", pc_o, {32'h4, 32'h0});
    chk("t1_full_inst", inst_o, {32'h4, 32'h0});
    chk("t1_full_req", 64'(imem_req_o), 64'd0);
    tick();

    // Streaming at two per cycle: no bubbles after the initial latency.
    do_reset();
    deq_count_i = 2'd2;
    for (int k = 0; k < 40; k++) exp_q.push_back(32'(4*k));
    for (int c = 0; c < 22; c++) begin
      settle();
      chk("t2_valid", 64'(valid_o), (c < 2) ? 64'd0 : 64'd3);
      tick();
    end
    chk("t2_drain", 64'(exp_q.size()), 64'd0);

    // Redirect to an unaligned PC mid-block.
    redirect_i = 1'b1; redirect_pc_i = 32'h106; deq_count_i = 2'd0;
    settle();
    chk("t3_req_redir", 64'(imem_req_o), 64'd0);
    tick();
    redirect_i = 1'b0;
    exp_q.push_back(32'h104); exp_q.push_back(32'h108); exp_q.push_back(32'h10C);
    settle();
    chk("t3_cnt_r1", 64'(count_o), 64'd0);
    chk("t3_req_r1", 64'(imem_req_o), 64'd1);
    chk("t3_addr_r1", 64'(imem_addr_o), 64'h20);
    tick();
    settle();
    chk("t3_cnt_r2", 64'(count_o), 64'd0);
    chk("t3_addr_r2", 64'(imem_addr_o), 64'h21);
    tick();
    deq_count_i = 2'd1;
    settle();
    chk("t3_cnt_r3", 64'(count_o), 64'd1);
    chk("t3_val_r3", 64'(valid_o), 64'd1);
    chk("t3_pc1_zero", 64'(pc_o[63:32]), 64'd0);
    chk("t3_inst1_zero", 64'(inst_o[63:32]), 64'd0);
    tick();
    deq_count_i = 2'd2;
    settle();
    chk("t3_cnt_r4", 64'(count_o), 64'd2);
    chk("t3_val_r4", 64'(valid_o), 64'd3);
    chk("t4_req_pre", 64'(imem_req_o), 64'd1);
    tick();

    // Redirect in the cycle a response returns: that response is dropped.
    redirect_i = 1'b1; redirect_pc_i = 32'h200; deq_count_i = 2'd0;
    settle();
    chk("t4_cnt_q", 64'(count_o), 64'd2);
    chk("t3_drain", 64'(exp_q.size()), 64'd0);
    tick();
    redirect_i = 1'b0; deq_count_i = 2'd2;
    for (int k = 0; k < 12; k++) exp_q.push_back(32'h200 + 32'(4*k));
    for (int c = 1; c <= 8; c++) begin
      settle();
      if (c <= 2) chk("t4_cnt_empty", 64'(count_o), 64'd0);
      else        chk("t4_valid", 64'(valid_o), 64'd3);
      tick();
    end
    chk("t4_drain", 64'(exp_q.size()), 64'd0);

    // One per cycle: pointers wrap many times, occupancy stays bounded.
    do_reset();
    deq_count_i = 2'd1;
    for (int k = 0; k < 38; k++) exp_q.push_back(32'(4*k));
    for (int c = 0; c < 40; c++) begin
      settle();
      chk("t5_bound", 64'(count_o <= 4'd8), 64'd1);
      if (c >= 2) chk("t5_valid0", 64'(valid_o[0]), 64'd1);
      tick();
    end
    chk("t5_drain", 64'(exp_q.size()), 64'd0);

    // Dequeue clamp with one entry, then reset with six entries held.
    redirect_i = 1'b1; redirect_pc_i = 32'h10F; deq_count_i = 2'd0;
    tick();
    redirect_i = 1'b0;
    settle();
    chk("t6_cnt_r1", 64'(count_o), 64'd0);
    chk("t6_addr_r1", 64'(imem_addr_o), 64'h21);
    tick();
    tick();
    deq_count_i = 2'd2;
    exp_q.push_back(32'h10C);
    settle();
    chk("t6_cnt_one", 64'(count_o), 64'd1);
    chk("t6_val_one", 64'(valid_o), 64'd1);
    tick();
    deq_count_i = 2'd0;
    settle();
    chk("t6_clamp", 64'(count_o), 64'd2);
    tick();
    settle();
    chk("t6_cnt4", 64'(count_o), 64'd4);
    tick();
    reset_n_i = 1'b0;
    settle();
    chk("t6_cnt6", 64'(count_o), 64'd6);
    chk("t6_req_rst", 64'(imem_req_o), 64'd0);
    tick();
    settle();
    chk("t6_cnt_rst", 64'(count_o), 64'd0);
    chk("t6_val_rst", 64'(valid_o), 64'd0);
    chk("t6_pc_rst", pc_o, 64'd0);
    chk("t6_req_rst2", 64'(imem_req_o), 64'd0);
    tick();
    reset_n_i = 1'b1;
    settle();
    chk("t6_req_after", 64'(imem_req_o), 64'd1);
    chk("t6_addr_after", 64'(imem_addr_o), 64'd0);
    chk("t6_drain", 64'(exp_q.size()), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
